// File: rtl/axi_ar_route_decoder.sv
// AR address decoder for one target port: region match, in-order steering and decode-error capture.
// Optional decode-error counter (err_count_o) under `AXI_AR_ERR_CNT_EN.

module axi_ar_route_match #(
  parameter int N_REGION   = 2,
  parameter int AXI_ADDR_W = 32
) (
  input  logic [AXI_ADDR_W-1:0]               addr_i,
  input  logic [N_REGION-1:0][AXI_ADDR_W-1:0] start_i,
  input  logic [N_REGION-1:0][AXI_ADDR_W-1:0] end_i,
  input  logic [N_REGION-1:0]                 en_i,
  input  logic                                conn_i,
  output logic                                hit_o
);
  logic any_hit;

  always_comb begin
    any_hit = 1'b0;
    for (int r = 0; r < N_REGION; r++)
      if (en_i[r] && (addr_i >= start_i[r]) && (addr_i <= end_i[r])) any_hit = 1'b1;
  end

  assign hit_o = conn_i & any_hit;
endmodule

module axi_ar_route_decoder #(
  parameter int N_INIT_PORT = 8,
  parameter int N_REGION    = 2,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                arvalid_i,
  input  logic [AXI_ADDR_W-1:0]                               araddr_i,
  input  logic [AXI_ID_IN-1:0]                                arid_i,
  input  logic [7:0]                                          arlen_i,
  input  logic [AXI_USER_W-1:0]                               aruser_i,
  output logic                                                arready_o,
  output logic [N_INIT_PORT-1:0]                              arvalid_o,
  input  logic [N_INIT_PORT-1:0]                              arready_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][AXI_ADDR_W-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][AXI_ADDR_W-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                enable_region_i,
  input  logic [N_INIT_PORT-1:0]                              connectivity_map_i,
  output logic                                                incr_req_o,
  input  logic                                                full_counter_i,
  input  logic                                                outstanding_trans_i,
  output logic                                                error_req_o,
  input  logic                                                error_gnt_i,
  output logic [7:0]                                          error_len_o,
  output logic [AXI_ID_IN-1:0]                                error_id_o,
  output logic [AXI_USER_W-1:0]                               error_user_o,
  output logic                                                sample_ardata_info_o
`ifdef AXI_AR_ERR_CNT_EN
  ,
  output logic [15:0]                                         err_count_o
`endif
);
  typedef enum logic {OPERATIVE = 1'b0, ERR_WAIT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [N_INIT_PORT-1:0]  match, dest;
  logic [N_INIT_PORT-1:0]  last_dest_q;
  logic                    last_dest_valid_q;
  logic [7:0]              err_len_q;
  logic [AXI_ID_IN-1:0]    err_id_q;
  logic [AXI_USER_W-1:0]   err_user_q;
  logic                    sample_q;
  logic                    stall, hit_any, route_hs, err_hs, found;

  for (genvar j = 0; j < N_INIT_PORT; j++) begin : g_lane
    logic [N_REGION-1:0][AXI_ADDR_W-1:0] st, en_a;
    logic [N_REGION-1:0]                 en;
    always_comb begin
      for (int r = 0; r < N_REGION; r++) begin
        st[r]   = START_ADDR_i[r][j];
        en_a[r] = END_ADDR_i[r][j];
        en[r]   = enable_region_i[r][j];
      end
    end
    axi_ar_route_match #(.N_REGION(N_REGION), .AXI_ADDR_W(AXI_ADDR_W)) u_match (
      .addr_i (araddr_i),
      .start_i(st),
      .end_i  (en_a),
      .en_i   (en),
      .conn_i (connectivity_map_i[j]),
      .hit_o  (match[j])
    );
  end

  // Lowest-index hit wins when regions overlap.
  always_comb begin
    dest  = '0;
    found = 1'b0;
    for (int j = 0; j < N_INIT_PORT; j++)
      if (match[j] && !found) begin
        dest[j] = 1'b1;
        found   = 1'b1;
      end
  end

  assign hit_any = |match;
  // Switching destination waits for outstanding reads so responses stay in order.
  assign stall   = full_counter_i |
                   (outstanding_trans_i & last_dest_valid_q & (dest != last_dest_q));

  always_comb begin
    state_d    = state_q;
    arvalid_o  = '0;
    arready_o  = 1'b0;
    incr_req_o = 1'b0;
    route_hs   = 1'b0;
    err_hs     = 1'b0;
    case (state_q)
      OPERATIVE: begin
        if (arvalid_i) begin
          if (hit_any) begin
            if (!stall) begin
              arvalid_o  = dest;
              arready_o  = |(dest & arready_i);
              route_hs   = arready_o;
              incr_req_o = arready_o;
            end
          end else begin
            arready_o = 1'b1;
            err_hs    = 1'b1;
            state_d   = ERR_WAIT;
          end
        end
      end
      ERR_WAIT: if (error_gnt_i) state_d = OPERATIVE;
      default:  state_d = OPERATIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= OPERATIVE;
      last_dest_q       <= '0;
      last_dest_valid_q <= 1'b0;
      err_len_q         <= '0;
      err_id_q          <= '0;
      err_user_q        <= '0;
      sample_q          <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= err_hs;
      if (route_hs) begin
        last_dest_q       <= dest;
        last_dest_valid_q <= 1'b1;
      end
      if (err_hs) begin
        err_len_q  <= arlen_i;
        err_id_q   <= arid_i;
        err_user_q <= aruser_i;
      end
    end
  end

  assign error_req_o          = (state_q == ERR_WAIT);
  assign sample_ardata_info_o = sample_q;
  assign error_len_o          = err_len_q;
  assign error_id_o           = err_id_q;
  assign error_user_o         = err_user_q;

`ifdef AXI_AR_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            err_cnt_q <= '0;
    else if (err_hs && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign err_count_o = err_cnt_q;
`endif
endmodule
